// File: rtl/pipeline_reg_exmem_p.sv
// EX/MEM pipeline register with valid bit, one-entry skid buffer, flush and branch hold of the ALU field.
// Optional stall cycle counter enabled by defining EXMEM_STALL_CNT_EN.
module pipeline_reg_exmem_p #(
    parameter int DW = 8,
    parameter int RW = 4,
    parameter int OW = 2*DW+RW+4
) (
    input  logic          nclk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] data_to_mem,
    input  logic [RW-1:0] reg_dest,
    input  logic          reg_write,
    input  logic          rd_en,
    input  logic          wr_en,
    input  logic          mem_to_reg,
    input  logic          branch,
    input  logic          mem_stall,
    input  logic          flush,
    output logic          ex_stall,
    output logic          mem_valid,
    output logic [OW-1:0] data_out
`ifdef EXMEM_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    logic [DW-1:0] out_alu_q, out_alu_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [RW-1:0] out_rd_q, out_rd_d;
    logic [3:0]    out_ctrl_q, out_ctrl_d;
    logic          mem_valid_q, mem_valid_d;

    logic [DW-1:0] skid_alu_q, skid_alu_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic [RW-1:0] skid_rd_q, skid_rd_d;
    logic [3:0]    skid_ctrl_q, skid_ctrl_d;
    logic          skid_branch_q, skid_branch_d;
    logic          skid_valid_q, skid_valid_d;

    logic       accept;
    logic       out_free;
    logic [3:0] in_ctrl;

    assign in_ctrl  = {reg_write, rd_en, wr_en, mem_to_reg};
    assign accept   = ex_valid & ~skid_valid_q;
    assign out_free = ~mem_valid_q | ~mem_stall;

    always_comb begin
        out_alu_d     = out_alu_q;
        out_data_d    = out_data_q;
        out_rd_d      = out_rd_q;
        out_ctrl_d    = out_ctrl_q;
        mem_valid_d   = mem_valid_q;
        skid_alu_d    = skid_alu_q;
        skid_data_d   = skid_data_q;
        skid_rd_d     = skid_rd_q;
        skid_ctrl_d   = skid_ctrl_q;
        skid_branch_d = skid_branch_q;
        skid_valid_d  = skid_valid_q;

        if (flush) begin
            mem_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            out_ctrl_d   = 4'b0;
        end else if (out_free && skid_valid_q) begin
            // Skid drains first so arrival order is preserved
            if (!skid_branch_q) out_alu_d = skid_alu_q;
            out_data_d   = skid_data_q;
            out_rd_d     = skid_rd_q;
            out_ctrl_d   = skid_ctrl_q;
            mem_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
        end else if (out_free && accept) begin
            if (!branch) out_alu_d = alu_result;
            out_data_d  = data_to_mem;
            out_rd_d    = reg_dest;
            out_ctrl_d  = in_ctrl;
            mem_valid_d = 1'b1;
        end else if (out_free) begin
            mem_valid_d = 1'b0;
            out_ctrl_d  = 4'b0;
        end else if (accept) begin
            skid_alu_d    = alu_result;
            skid_data_d   = data_to_mem;
            skid_rd_d     = reg_dest;
            skid_ctrl_d   = in_ctrl;
            skid_branch_d = branch;
            skid_valid_d  = 1'b1;
        end
    end

    always_ff @(posedge nclk) begin
        if (rst) begin
            out_alu_q     <= '0;
            out_data_q    <= '0;
            out_rd_q      <= '0;
            out_ctrl_q    <= '0;
            mem_valid_q   <= 1'b0;
            skid_alu_q    <= '0;
            skid_data_q   <= '0;
            skid_rd_q     <= '0;
            skid_ctrl_q   <= '0;
            skid_branch_q <= 1'b0;
            skid_valid_q  <= 1'b0;
        end else begin
            out_alu_q     <= out_alu_d;
            out_data_q    <= out_data_d;
            out_rd_q      <= out_rd_d;
            out_ctrl_q    <= out_ctrl_d;
            mem_valid_q   <= mem_valid_d;
            skid_alu_q    <= skid_alu_d;
            skid_data_q   <= skid_data_d;
            skid_rd_q     <= skid_rd_d;
            skid_ctrl_q   <= skid_ctrl_d;
            skid_branch_q <= skid_branch_d;
            skid_valid_q  <= skid_valid_d;
        end
    end

    assign ex_stall  = skid_valid_q;
    assign mem_valid = mem_valid_q;
    assign data_out  = {out_ctrl_q, out_rd_q, out_data_q, out_alu_q};

`ifdef EXMEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (mem_valid_q && mem_stall && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge nclk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_reg_exmem_p.sv
// Directed self-checking bench for pipeline_reg_exmem_p: a DW=8 instance and a DW=16/RW=5 instance.
module tb_pipeline_reg_exmem_p;

    logic nclk = 1'b0;
    logic rst  = 1'b1;
    always #5 nclk = ~nclk;

    int total = 0;
    int bad   = 0;

    // DW=8, RW=4 instance signals
    logic        a_ex_valid, a_branch, a_mem_stall, a_flush;
    logic [7:0]  a_alu, a_data;
    logic [3:0]  a_rd, a_ctrl;
    logic        a_ex_stall, a_mem_valid;
    logic [23:0] a_out;

    // DW=16, RW=5 instance signals
    logic        b_ex_valid, b_branch, b_mem_stall, b_flush;
    logic [15:0] b_alu, b_data;
    logic [4:0]  b_rd;
    logic [3:0]  b_ctrl;
    logic        b_ex_stall, b_mem_valid;
    logic [40:0] b_out;

`ifdef EXMEM_STALL_CNT_EN
    logic [15:0] a_cnt, b_cnt;
`endif

    pipeline_reg_exmem_p u_dut8 (
        .nclk(nclk), .rst(rst), .ex_valid(a_ex_valid),
        .alu_result(a_alu), .data_to_mem(a_data), .reg_dest(a_rd),
        .reg_write(a_ctrl[3]), .rd_en(a_ctrl[2]), .wr_en(a_ctrl[1]), .mem_to_reg(a_ctrl[0]),
        .branch(a_branch), .mem_stall(a_mem_stall), .flush(a_flush),
        .ex_stall(a_ex_stall), .mem_valid(a_mem_valid), .data_out(a_out)
`ifdef EXMEM_STALL_CNT_EN
        , .stall_cnt(a_cnt)
`endif
    );

    pipeline_reg_exmem_p #(.DW(16), .RW(5)) u_dut16 (
        .nclk(nclk), .rst(rst), .ex_valid(b_ex_valid),
        .alu_result(b_alu), .data_to_mem(b_data), .reg_dest(b_rd),
        .reg_write(b_ctrl[3]), .rd_en(b_ctrl[2]), .wr_en(b_ctrl[1]), .mem_to_reg(b_ctrl[0]),
        .branch(b_branch), .mem_stall(b_mem_stall), .flush(b_flush),
        .ex_stall(b_ex_stall), .mem_valid(b_mem_valid), .data_out(b_out)
`ifdef EXMEM_STALL_CNT_EN
        , .stall_cnt(b_cnt)
`endif
    );

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [7:0] alu, input logic [7:0] dat,
                                  input logic [3:0] rd, input logic [3:0] ctrl, input logic br,
                                  input logic st, input logic fl);
        a_ex_valid = v; a_alu = alu; a_data = dat; a_rd = rd;
        a_ctrl = ctrl; a_branch = br; a_mem_stall = st; a_flush = fl;
    endtask

    task automatic apply_stimulus16(input logic v, input logic [15:0] alu, input logic [15:0] dat,
                                    input logic [4:0] rd, input logic [3:0] ctrl, input logic st);
        b_ex_valid = v; b_alu = alu; b_data = dat; b_rd = rd;
        b_ctrl = ctrl; b_branch = 1'b0; b_mem_stall = st; b_flush = 1'b0;
    endtask

    task automatic step();
        @(posedge nclk);
        #1;
    endtask

    initial begin
        // Reset with every input nonzero
        apply_stimulus(1'b1, 8'hFF, 8'hFF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1);
        b_ex_valid = 1'b1; b_alu = 16'hFFFF; b_data = 16'hFFFF; b_rd = 5'h1F;
        b_ctrl = 4'hF; b_branch = 1'b1; b_mem_stall = 1'b1; b_flush = 1'b1;
        step();
        step();
        rst = 1'b0;
        apply_stimulus(1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        apply_stimulus16(1'b0, 16'h0, 16'h0, 5'h0, 4'h0, 1'b0);
        check_output("rst_data_out", {40'b0, a_out}, 64'h0);
        check_output("rst_mem_valid", {63'b0, a_mem_valid}, 64'h0);
        check_output("rst_ex_stall", {63'b0, a_ex_stall}, 64'h0);
        check_output("rst16_data_out", {23'b0, b_out}, 64'h0);

        // Passthrough
        apply_stimulus(1'b1, 8'h3C, 8'hA5, 4'h7, 4'b1001, 1'b0, 1'b0, 1'b0);
        step();
        check_output("pass_data_out", {40'b0, a_out}, 64'h97A53C);
        check_output("pass_mem_valid", {63'b0, a_mem_valid}, 64'h1);
        apply_stimulus(1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        check_output("bubble_mem_valid", {63'b0, a_mem_valid}, 64'h0);
        check_output("bubble_data_out", {40'b0, a_out}, 64'h07A53C);

        // Branch hold of the ALU field
        apply_stimulus(1'b1, 8'h11, 8'h22, 4'h3, 4'b1000, 1'b0, 1'b0, 1'b0);
        step();
        check_output("br_first", {40'b0, a_out}, 64'h832211);
        apply_stimulus(1'b1, 8'hEE, 8'h44, 4'h2, 4'b0100, 1'b1, 1'b0, 1'b0);
        step();
        check_output("br_alu_hold", {56'b0, a_out[7:0]}, 64'h11);
        check_output("br_reg_dest", {60'b0, a_out[19:16]}, 64'h2);
        check_output("br_data_out", {40'b0, a_out}, 64'h424411);
        apply_stimulus(1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();

        // Stall and skid ordering: A, B, C
        apply_stimulus(1'b1, 8'h01, 8'h10, 4'h1, 4'b1000, 1'b0, 1'b0, 1'b0);
        step();
        check_output("skid_A_out", {40'b0, a_out}, 64'h811001);
        apply_stimulus(1'b1, 8'h02, 8'h20, 4'h2, 4'b0100, 1'b0, 1'b1, 1'b0);
        step();
        check_output("skid_A_held", {40'b0, a_out}, 64'h811001);
        check_output("skid_ex_stall", {63'b0, a_ex_stall}, 64'h1);
        apply_stimulus(1'b1, 8'h03, 8'h30, 4'h3, 4'b0010, 1'b0, 1'b1, 1'b0);
        step();
        check_output("skid_hold_out", {40'b0, a_out}, 64'h811001);
        check_output("skid_hold_stall", {63'b0, a_ex_stall}, 64'h1);
        a_mem_stall = 1'b0;
        step();
        check_output("skid_B_out", {40'b0, a_out}, 64'h422002);
        check_output("skid_B_valid", {63'b0, a_mem_valid}, 64'h1);
        check_output("skid_B_stall", {63'b0, a_ex_stall}, 64'h0);
        step();
        check_output("skid_C_out", {40'b0, a_out}, 64'h233003);
        apply_stimulus(1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        check_output("skid_drain_valid", {63'b0, a_mem_valid}, 64'h0);

        // Branch entry passing through the skid keeps the previous ALU value
        apply_stimulus(1'b1, 8'h55, 8'h66, 4'h4, 4'b0001, 1'b0, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b1, 8'hFF, 8'h77, 4'h5, 4'b1100, 1'b1, 1'b1, 1'b0);
        step();
        apply_stimulus(1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        check_output("skid_branch_out", {40'b0, a_out}, 64'hC57755);
        step();

        // Flush with output and skid both valid
        apply_stimulus(1'b1, 8'h01, 8'h10, 4'h1, 4'b1000, 1'b0, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b1, 8'h02, 8'h20, 4'h2, 4'b0100, 1'b0, 1'b1, 1'b0);
        step();
        check_output("flush_pre_stall", {63'b0, a_ex_stall}, 64'h1);
        apply_stimulus(1'b1, 8'h09, 8'h90, 4'h9, 4'b1111, 1'b0, 1'b1, 1'b1);
        step();
        check_output("flush_mem_valid", {63'b0, a_mem_valid}, 64'h0);
        check_output("flush_ex_stall", {63'b0, a_ex_stall}, 64'h0);
        check_output("flush_data_out", {40'b0, a_out}, 64'h011001);
        apply_stimulus(1'b0, 8'h00, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        step();
        check_output("flush_dropped", {63'b0, a_mem_valid}, 64'h0);

        // DW=16, RW=5 instance: passthrough and skid
        apply_stimulus16(1'b1, 16'h1234, 16'hABCD, 5'h15, 4'b1010, 1'b0);
        step();
        check_output("w16_pass", {23'b0, b_out}, {23'b0, 4'b1010, 5'h15, 16'hABCD, 16'h1234});
        check_output("w16_alu", {48'b0, b_out[15:0]}, 64'h1234);
        check_output("w16_data", {48'b0, b_out[31:16]}, 64'hABCD);
        check_output("w16_rd", {59'b0, b_out[36:32]}, 64'h15);
        check_output("w16_ctrl", {60'b0, b_out[40:37]}, 64'hA);
        apply_stimulus16(1'b1, 16'h5678, 16'h9ABC, 5'h0B, 4'b0101, 1'b1);
        step();
        check_output("w16_skid_hold", {23'b0, b_out}, {23'b0, 4'b1010, 5'h15, 16'hABCD, 16'h1234});
        check_output("w16_ex_stall", {63'b0, b_ex_stall}, 64'h1);
        apply_stimulus16(1'b0, 16'h0, 16'h0, 5'h0, 4'h0, 1'b0);
        step();
        check_output("w16_skid_out", {23'b0, b_out}, {23'b0, 4'b0101, 5'h0B, 16'h9ABC, 16'h5678});
        check_output("w16_skid_valid", {63'b0, b_mem_valid}, 64'h1);
        step();
        check_output("w16_bubble", {63'b0, b_mem_valid}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
